// File: rtl/cdf_datapath_if.sv
// CDF datapath bundle: controller strobes, scratch-memory read/write ports and status.
//   master: controller/memory side (drives strobes and read data)
//   slave : cdf_datapath side (drives memory strobes, addresses, write data, status)
interface cdf_datapath_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) ();
    logic              read_first_value;
    logic              read_next_value;
    logic              scratch_mem_read_ready;
    logic              cdf_computation_done;
    logic              cdf_done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              image_done;
    logic              protocol_err;

    modport master (
        output read_first_value, read_next_value, scratch_mem_read_ready,
               cdf_computation_done, cdf_done, mem_rd_data,
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
               image_done, protocol_err
    );

    modport slave (
        input  read_first_value, read_next_value, scratch_mem_read_ready,
               cdf_computation_done, cdf_done, mem_rd_data,
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
               image_done, protocol_err
    );
endinterface

// File: rtl/cdf_datapath.sv
// CDF datapath: fetches histogram bins, keeps the running cumulative sum and
// writes each CDF entry back as a low half and a high half.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - cdf_datapath_if.slave (controller strobes, scratch read/write, status)
module cdf_datapath #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned NUM_BINS  = 64,
    parameter int unsigned HIST_BASE = 0,
    parameter int unsigned CDF_BASE  = 64
) (
    input  logic           clk,
    input  logic           reset,
    cdf_datapath_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_BINS + 1);
    localparam int unsigned ACC_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ACCUM = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] lat_q, lat_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;
    logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
    logic              image_done_q, image_done_d;
    logic              protocol_err_q, protocol_err_d;

    logic [ADDR_W-1:0] cdf_lo_addr_c;
    logic              any_read_c;

    assign cdf_lo_addr_c = ADDR_W'(CDF_BASE) + (ADDR_W'(idx_q) << 1);
    assign any_read_c    = bus.read_first_value | bus.read_next_value;

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        lat_d          = lat_q;
        mem_rd_en_d    = 1'b0;
        mem_rd_addr_d  = mem_rd_addr_q;
        mem_wr_en_d    = 1'b0;
        mem_wr_addr_d  = mem_wr_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        image_done_d   = 1'b0;
        protocol_err_d = protocol_err_q;

        if (bus.cdf_done) begin
            // Image end overrides everything else arriving in the same cycle
            image_done_d = 1'b1;
            idx_d        = '0;
            state_d      = IDLE;
            if (state_q != IDLE) begin
                protocol_err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.read_first_value) begin
                        idx_d          = '0;
                        acc_d          = '0;
                        protocol_err_d = bus.read_next_value;
                        mem_rd_en_d    = 1'b1;
                        mem_rd_addr_d  = ADDR_W'(HIST_BASE);
                        state_d        = FETCH;
                    end else if (bus.read_next_value) begin
                        if (idx_q < IDX_W'(NUM_BINS)) begin
                            mem_rd_en_d   = 1'b1;
                            mem_rd_addr_d = ADDR_W'(HIST_BASE) + ADDR_W'(idx_q);
                            state_d       = FETCH;
                        end else begin
                            protocol_err_d = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (bus.scratch_mem_read_ready) begin
                        lat_d   = bus.mem_rd_data;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    acc_d   = acc_q + ACC_W'(lat_q);
                    state_d = WR_LO;
                end
                WR_LO: begin
                    if (bus.cdf_computation_done) begin
                        mem_wr_en_d   = 1'b1;
                        mem_wr_addr_d = cdf_lo_addr_c;
                        mem_wr_data_d = acc_q[DATA_W-1:0];
                        state_d       = WR_HI;
                    end
                end
                WR_HI: begin
                    if (bus.cdf_computation_done) begin
                        mem_wr_en_d   = 1'b1;
                        mem_wr_addr_d = cdf_lo_addr_c + ADDR_W'(1);
                        mem_wr_data_d = acc_q[ACC_W-1:DATA_W];
                        idx_d         = idx_q + IDX_W'(1);
                        state_d       = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Out-of-place strobes flag an error; applied last so they win over the clear
            if (any_read_c && (state_q != IDLE)) begin
                protocol_err_d = 1'b1;
            end
            if (bus.scratch_mem_read_ready && (state_q != FETCH)) begin
                protocol_err_d = 1'b1;
            end
            if (bus.cdf_computation_done && (state_q != WR_LO) && (state_q != WR_HI)) begin
                protocol_err_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            lat_q          <= '0;
            mem_rd_en_q    <= 1'b0;
            mem_rd_addr_q  <= '0;
            mem_wr_en_q    <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
            image_done_q   <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            lat_q          <= lat_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_rd_addr_q  <= mem_rd_addr_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_wr_addr_q  <= mem_wr_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            image_done_q   <= image_done_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign bus.mem_rd_en    = mem_rd_en_q;
    assign bus.mem_rd_addr  = mem_rd_addr_q;
    assign bus.mem_wr_en    = mem_wr_en_q;
    assign bus.mem_wr_addr  = mem_wr_addr_q;
    assign bus.mem_wr_data  = mem_wr_data_q;
    assign bus.image_done   = image_done_q;
    assign bus.protocol_err = protocol_err_q;
endmodule

// File: tb/tb_cdf_datapath.sv
// Bench for cdf_datapath: scratch-memory model, controller-style directed
// sequences with random bin contents, and a cumulative-sum reference model.
module tb_cdf_datapath;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned NUM_BINS  = 64;
    localparam int unsigned HIST_BASE = 0;
    localparam int unsigned CDF_BASE  = 64;

    logic clk;
    logic reset;

    cdf_datapath_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    cdf_datapath #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BINS(NUM_BINS),
        .HIST_BASE(HIST_BASE), .CDF_BASE(CDF_BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] hist    [NUM_BINS];
    logic [DATA_W-1:0] cdf_mem [256];
    int                wr_count = 0;

    // Scratch memory: 1-cycle read latency, captures every write strobe
    always @(posedge clk) begin
        int unsigned a;
        a = 32'(bus.mem_rd_addr);
        if (bus.mem_rd_en) begin
            if (a >= HIST_BASE && a < HIST_BASE + NUM_BINS)
                bus.mem_rd_data <= hist[a - HIST_BASE];
            else
                bus.mem_rd_data <= 16'hDEAD;
        end
        if (bus.mem_wr_en) begin
            cdf_mem[bus.mem_wr_addr] <= bus.mem_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    int          n_checks = 0;
    int          n_err    = 0;
    longint unsigned acc_m = 0;
    logic        err_m    = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One bin: read strobe, fetch, two write-back pulses spaced 3 cycles apart
    task automatic run_bin(input bit first, input bit both, input int k);
        logic [31:0] s;
        if (first) begin
            bus.read_first_value = 1'b1;
            bus.read_next_value  = both;
        end else begin
            bus.read_next_value = 1'b1;
        end
        tick();
        bus.read_first_value = 1'b0;
        bus.read_next_value  = 1'b0;
        chk("rd_en", 32'(bus.mem_rd_en), 32'd1);
        chk("rd_addr", 32'(bus.mem_rd_addr), HIST_BASE + 32'(k));
        tick();
        chk("rd_en_one_cycle", 32'(bus.mem_rd_en), 32'd0);
        bus.scratch_mem_read_ready = 1'b1;
        tick();
        bus.scratch_mem_read_ready = 1'b0;
        if (first) begin
            acc_m = 0;
            err_m = both;
        end
        acc_m = acc_m + longint'(hist[k]);
        s = acc_m[31:0];
        tick();
        tick();
        bus.cdf_computation_done = 1'b1;
        tick();
        bus.cdf_computation_done = 1'b0;
        chk("wr_en_lo", 32'(bus.mem_wr_en), 32'd1);
        chk("wr_addr_lo", 32'(bus.mem_wr_addr), CDF_BASE + 32'(2 * k));
        chk("wr_data_lo", 32'(bus.mem_wr_data), {16'h0, s[15:0]});
        tick();
        chk("wr_en_gap", 32'(bus.mem_wr_en), 32'd0);
        tick();
        tick();
        bus.cdf_computation_done = 1'b1;
        tick();
        bus.cdf_computation_done = 1'b0;
        chk("wr_en_hi", 32'(bus.mem_wr_en), 32'd1);
        chk("wr_addr_hi", 32'(bus.mem_wr_addr), CDF_BASE + 32'(2 * k + 1));
        chk("wr_data_hi", 32'(bus.mem_wr_data), {16'h0, s[31:16]});
        tick();
        chk("wr_en_end", 32'(bus.mem_wr_en), 32'd0);
        chk("protocol_err", 32'(bus.protocol_err), 32'(err_m));
    endtask

    task automatic run_image();
        for (int k = 0; k < int'(NUM_BINS); k++) run_bin(k == 0, 1'b0, k);
    endtask

    task automatic finish_image();
        bus.cdf_done = 1'b1;
        tick();
        bus.cdf_done = 1'b0;
        chk("image_done", 32'(bus.image_done), 32'd1);
        chk("err_at_done", 32'(bus.protocol_err), 32'(err_m));
        tick();
        chk("image_done_pulse", 32'(bus.image_done), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(bus.mem_rd_addr), 32'd0);
        chk({tag, "_wr_en"}, 32'(bus.mem_wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(bus.mem_wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(bus.mem_wr_data), 32'd0);
        chk({tag, "_image_done"}, 32'(bus.image_done), 32'd0);
        chk({tag, "_protocol_err"}, 32'(bus.protocol_err), 32'd0);
    endtask

    initial begin
        int wc;
        bus.read_first_value       = 1'b0;
        bus.read_next_value        = 1'b0;
        bus.scratch_mem_read_ready = 1'b0;
        bus.cdf_computation_done   = 1'b0;
        bus.cdf_done               = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        tick();
        chk_outputs_zero("reset");
        reset = 1'b0;
        tick();

        // Image 1: every bin is 1 -> entry k is k+1
        for (int k = 0; k < int'(NUM_BINS); k++) hist[k] = 16'd1;
        wc = wr_count;
        run_image();
        finish_image();
        chk("write_count_img1", 32'(wr_count - wc), 32'd128);
        for (int k = 0; k < int'(NUM_BINS); k++) begin
            chk("img1_lo", 32'(cdf_mem[CDF_BASE + 2 * k]), 32'(k + 1));
            chk("img1_hi", 32'(cdf_mem[CDF_BASE + 2 * k + 1]), 32'd0);
        end

        // Image 2: every bin saturated
        for (int k = 0; k < int'(NUM_BINS); k++) hist[k] = 16'hFFFF;
        run_image();
        finish_image();
        chk("img2_addr64", 32'(cdf_mem[64]), 32'h0000_FFFF);
        chk("img2_addr65", 32'(cdf_mem[65]), 32'h0000_0000);
        chk("img2_addr190", 32'(cdf_mem[190]), 32'h0000_FFC0);
        chk("img2_addr191", 32'(cdf_mem[191]), 32'h0000_003F);

        // Image 3: random bins
        for (int k = 0; k < int'(NUM_BINS); k++) hist[k] = 16'($urandom);
        run_image();
        finish_image();

        // Ready strobe in IDLE flags an error and leaves the sum alone
        bus.scratch_mem_read_ready = 1'b1;
        tick();
        bus.scratch_mem_read_ready = 1'b0;
        err_m = 1'b1;
        chk("srr_idle_err", 32'(bus.protocol_err), 32'd1);
        chk("srr_idle_no_rd", 32'(bus.mem_rd_en), 32'd0);
        run_bin(1'b0, 1'b0, 0);
        finish_image();

        // Image 4: read_first clears the error; 65th read_next is refused
        for (int k = 0; k < int'(NUM_BINS); k++) hist[k] = 16'($urandom);
        run_image();
        bus.read_next_value = 1'b1;
        tick();
        bus.read_next_value = 1'b0;
        err_m = 1'b1;
        chk("bin65_no_rd", 32'(bus.mem_rd_en), 32'd0);
        chk("bin65_err", 32'(bus.protocol_err), 32'd1);
        tick();
        chk("bin65_no_rd_late", 32'(bus.mem_rd_en), 32'd0);
        finish_image();

        // Reset the cycle after the first write-back pulse
        hist[0] = 16'($urandom);
        bus.read_first_value = 1'b1;
        tick();
        bus.read_first_value = 1'b0;
        tick();
        bus.scratch_mem_read_ready = 1'b1;
        tick();
        bus.scratch_mem_read_ready = 1'b0;
        tick();
        tick();
        bus.cdf_computation_done = 1'b1;
        tick();
        chk("pre_reset_wr_en", 32'(bus.mem_wr_en), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.cdf_computation_done = 1'b0;
        chk_outputs_zero("mid_reset");
        wc = wr_count;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_no_wr", 32'(bus.mem_wr_en), 32'd0);
        end
        chk("post_reset_wr_count", 32'(wr_count), 32'(wc));
        err_m = 1'b0;
        run_bin(1'b1, 1'b0, 0);
        finish_image();

        // Simultaneous read strobes, then cdf_done while the high half is pending
        hist[0] = 16'($urandom);
        run_bin(1'b1, 1'b1, 0);
        bus.read_next_value = 1'b1;
        tick();
        bus.read_next_value = 1'b0;
        tick();
        bus.scratch_mem_read_ready = 1'b1;
        tick();
        bus.scratch_mem_read_ready = 1'b0;
        tick();
        tick();
        bus.cdf_computation_done = 1'b1;
        tick();
        bus.cdf_computation_done = 1'b0;
        chk("abort_wr_lo", 32'(bus.mem_wr_en), 32'd1);
        tick();
        wc = wr_count;
        bus.cdf_done = 1'b1;
        tick();
        bus.cdf_done = 1'b0;
        chk("abort_image_done", 32'(bus.image_done), 32'd1);
        chk("abort_err", 32'(bus.protocol_err), 32'd1);
        chk("abort_no_hi", 32'(bus.mem_wr_en), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("abort_wr_count", 32'(wr_count), 32'(wc));
        chk("abort_image_done_end", 32'(bus.image_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
